// File: rtl/rgb_fade_pwm_pkg.sv
// Shared constants and width helpers for the multi-channel fading PWM engine.
package rgb_fade_pkg;

   localparam int WIDTH_DEF       = 8;
   localparam int PRESCALE_DEF    = 46;
   localparam int STEP_FRAMES_DEF = 4;

   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) bits = i + 1;
      end
      return bits;
   endfunction

   // Counter/index width that never collapses to zero bits.
   function automatic int cnt_bits(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/rgb_fade_pwm_if.sv
// Channel load port: one valid/ready transfer carries channel, duty and fade mode.
interface rgb_fade_pwm_if
   import rgb_fade_pkg::*;
#(
   parameter int CW    = 2,
   parameter int WIDTH = WIDTH_DEF
);
   logic             load_valid;
   logic             load_ready;
   logic [CW-1:0]    load_chan;
   logic [WIDTH-1:0] load_duty;
   logic             load_fade;

   modport master (
      output load_valid, load_chan, load_duty, load_fade,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_chan, load_duty, load_fade,
      output load_ready
   );
endinterface

// File: rtl/rgb_fade_pwm_fade_channel.sv
// One PWM channel: current/target duty with +-1 ramp steps and a frame-aligned shadow.
module fade_channel
   import rgb_fade_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk12MHz,
   input  logic             rst_n,
   input  logic             load_stb,
   input  logic             load_fade,
   input  logic [WIDTH-1:0] load_duty,
   input  logic             step_ev,
   input  logic             frame_wrap,
   input  logic [WIDTH-1:0] pwm_cnt,
   output logic             pwm_bit,
   output logic             busy
);

   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pwm_q, pwm_d;
   logic             busy_q, busy_d;

   always_comb begin
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      shadow_d = frame_wrap ? cur_q : shadow_q;
      pwm_d    = (pwm_cnt < shadow_q);
      busy_d   = (cur_q != tgt_q);
      if (step_ev) begin
         if (cur_q < tgt_q) begin
            cur_d = cur_q + WIDTH'(1);
         end else if (cur_q > tgt_q) begin
            cur_d = cur_q - WIDTH'(1);
         end
      end
      // Loads never coincide with a step event, the top holds ready low then.
      if (load_stb) begin
         tgt_d = load_duty;
         if (!load_fade) cur_d = load_duty;
      end
   end

   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         cur_q    <= '0;
         tgt_q    <= '0;
         shadow_q <= '0;
         pwm_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
         busy_q   <= busy_d;
      end
   end

   assign pwm_bit = pwm_q;
   assign busy    = busy_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// Multi-channel PWM engine with per-channel linear fade; shared timebase plus
// load port decode feeding one fade_channel per output.
module rgb_fade_pwm
   import rgb_fade_pkg::*;
#(
   parameter int CHANNELS    = 3,
   parameter int WIDTH       = WIDTH_DEF,
   parameter int PRESCALE    = PRESCALE_DEF,
   parameter int STEP_FRAMES = STEP_FRAMES_DEF
) (
   input  logic                clk12MHz,
   input  logic                rst_n,
   rgb_fade_pwm_if.slave       load_if,
   output logic [CHANNELS-1:0] pwm_out,
   output logic [CHANNELS-1:0] busy,
   output logic                frame_start
);

   localparam int CW = cnt_bits(CHANNELS);
   localparam int PW = cnt_bits(PRESCALE + 1);
   localparam int SW = cnt_bits(STEP_FRAMES + 1);

   localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE);
   localparam logic [SW-1:0]    STEP_MAX  = SW'(STEP_FRAMES);
   localparam logic [WIDTH-1:0] CNT_MAX   = '1;

   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    step_q, step_d;
   logic             frame_start_q, frame_start_d;
   logic             tick, wrap, step_ev, accept;

   always_comb begin
      tick          = (presc_q == PRESC_MAX);
      wrap          = tick && (cnt_q == CNT_MAX);
      step_ev       = wrap && (step_q == STEP_MAX);
      presc_d       = tick ? '0 : presc_q + PW'(1);
      cnt_d         = tick ? cnt_q + WIDTH'(1) : cnt_q;
      step_d        = step_q;
      if (wrap) step_d = step_ev ? '0 : step_q + SW'(1);
      frame_start_d = wrap;
   end

   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         presc_q       <= '0;
         cnt_q         <= '0;
         step_q        <= '0;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         cnt_q         <= cnt_d;
         step_q        <= step_d;
         frame_start_q <= frame_start_d;
      end
   end

   // The step event owns every channel's cur register for that one cycle.
   assign load_if.load_ready = !step_ev;
   assign accept             = load_if.load_valid && !step_ev;
   assign frame_start        = frame_start_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      fade_channel #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk12MHz   (clk12MHz),
         .rst_n      (rst_n),
         .load_stb   (accept && (load_if.load_chan == CW'(c))),
         .load_fade  (load_if.load_fade),
         .load_duty  (load_if.load_duty),
         .step_ev    (step_ev),
         .frame_wrap (wrap),
         .pwm_cnt    (cnt_q),
         .pwm_bit    (pwm_out[c]),
         .busy       (busy[c])
      );
   end

endmodule
